// File: rtl/qdb_pkg.sv
// Shared types and the Gray-step decode used by every quadrature channel.
package qdb_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_e;

    // Position of an {A,B} sample along the forward sequence 00 -> 01 -> 11 -> 10
    function automatic logic [1:0] qdb_gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic step_e qdb_decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] delta;
        delta = qdb_gray_idx(cur) - qdb_gray_idx(prev);
        case (delta)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_UP;
            2'd3:    return STEP_DOWN;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: synchroniser, optional glitch filter (QDB_FILTER_EN),
// 4x decode, wrapping position counter and sticky illegal-step flag.
module quad_channel
    import qdb_pkg::*;
#(
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             dir_inv,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic [1:0]             syn_ab;
    logic                   syn_vld;
    logic [1:0]             cur_ab;
    logic                   cur_vld;
    logic [1:0]             prev_ab;
    logic                   primed;
    step_e                  step_c;

    // sync_vld tracks which stages hold post-reset samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            sync_vld <= '0;
        end else begin
            sync_a   <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b   <= {sync_b[SYNC_STAGES-2:0], b};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign syn_ab  = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign syn_vld = sync_vld[SYNC_STAGES-1];

`ifdef QDB_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

    logic [1:0]          acc_ab;
    logic                acc_vld;
    logic [1:0][FCW-1:0] fcnt;

    // A level is accepted once it has differed for FILTER_LEN consecutive clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_ab  <= '0;
            acc_vld <= 1'b0;
            fcnt    <= '0;
        end else if (syn_vld) begin
            acc_vld <= 1'b1;
            if (!acc_vld) begin
                acc_ab <= syn_ab;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (syn_ab[k] != acc_ab[k]) begin
                        if (fcnt[k] == FCW'(FILTER_LEN - 1)) begin
                            acc_ab[k] <= syn_ab[k];
                            fcnt[k]   <= '0;
                        end else begin
                            fcnt[k] <= fcnt[k] + FCW'(1);
                        end
                    end else begin
                        fcnt[k] <= '0;
                    end
                end
            end
        end
    end

    assign cur_ab  = acc_ab;
    assign cur_vld = acc_vld;
`else
    logic unused_filter_len;

    assign unused_filter_len = ^FILTER_LEN;
    assign cur_ab            = syn_ab;
    assign cur_vld           = syn_vld;
`endif

    // The first accepted sample only seeds the history, so it never counts
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab <= '0;
            primed  <= 1'b0;
        end else if (cur_vld) begin
            prev_ab <= cur_ab;
            primed  <= 1'b1;
        end
    end

    always_comb begin
        step_c = STEP_NONE;
        if (primed) begin
            step_c = qdb_decode(prev_ab, cur_ab);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (step_c)
                STEP_UP:      count <= dir_inv ? count - CNT_W'(1) : count + CNT_W'(1);
                STEP_DOWN:    count <= dir_inv ? count + CNT_W'(1) : count - CNT_W'(1);
                STEP_ILLEGAL: err   <= 1'b1;
                default:      ;
            endcase
        end
    end

endmodule

// File: rtl/quad_decoder_bank.sv
// Multi-channel quadrature decoder bank with coherent snapshot and registered read port.
// Optional glitch filter per input is enabled with QDB_FILTER_EN.
module quad_decoder_bank
    import qdb_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    localparam int unsigned AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    input  logic [CHANNELS-1:0] dir_inv,
    input  logic [CHANNELS-1:0] clr,
    input  logic                snap,
    input  logic                use_snap,
    input  logic [AW-1:0]       rd_addr,
    output logic [OUT_W-1:0]    rd_data,
    output logic [CHANNELS-1:0] err
);

    localparam int unsigned NSRC = 1 << AW;

    logic [CNT_W-1:0] live   [CHANNELS];
    logic [CNT_W-1:0] shadow [CHANNELS];
    logic [CNT_W-1:0] rd_src [NSRC];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        quad_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .a       (enc_a[i]),
            .b       (enc_b[i]),
            .dir_inv (dir_inv[i]),
            .clr     (clr[i]),
            .count   (live[i]),
            .err     (err[i])
        );
    end

    // Shadows take the pre-update counter values, so same-cycle steps or clears are excluded
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= live[i];
            end
        end
    end

    // Addresses beyond the last channel read as zero
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        if (i < CHANNELS) begin : g_used
            assign rd_src[i] = use_snap ? shadow[i] : live[i];
        end else begin : g_pad
            assign rd_src[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_src[rd_addr][CNT_W-1 -: OUT_W];
        end
    end

endmodule
